// File: rtl/fir_ctrl_pkg.sv
// Shared types for the hard-FIR load sequencer.
//   ctrl_state_t   : top-level sequencer states (exposed on fir_load_ctrl.state)
//   strobe_phase_t : phase of a single word transfer in fir_strobe_gen
//   RST_SEQ_LEN    : number of cycles spent in the filter reset sequence
package fir_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_SEQ,
        LOAD_COEF,
        LOAD_SCALE,
        RUN
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_SETUP,
        SP_PULSE
    } strobe_phase_t;

    localparam int RST_SEQ_LEN = 3;

endpackage

// File: rtl/fir_strobe_gen.sv
// Two-phase word transfer into the hard filter.
// A start in cycle N latches the word onto filt_in for cycle N+1 (setup).
// The selected strobe is high in cycle N+2 and low again in N+3.
// filt_in only changes on a start, and a start is only legal while idle.
// So filt_in is stable across every strobe.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   start          : accept word this cycle (caller guarantees busy == 0)
//   sel_sample     : 0 = coefficient/scale (coeff_strobe), 1 = sample (sample_strobe)
//   word           : data word to transfer
//   filt_in        : registered word driven to the filter
//   coeff_strobe   : registered clk_coeff pulse
//   sample_strobe  : registered clk_sample pulse
//   busy           : transfer in flight (setup or pulse phase)
//   phase          : current transfer phase (debug visibility)
import fir_ctrl_pkg::*;

module fir_strobe_gen #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sel_sample,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] filt_in,
    output logic              coeff_strobe,
    output logic              sample_strobe,
    output logic              busy,
    output strobe_phase_t     phase
);

    strobe_phase_t     phase_q;
    strobe_phase_t     phase_d;
    logic              sel_q;
    logic [DATA_W-1:0] word_q;
    logic              coeff_q;
    logic              sample_q;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            SP_IDLE:  if (start) phase_d = SP_SETUP;
            SP_SETUP: phase_d = SP_PULSE;
            SP_PULSE: phase_d = SP_IDLE;
            default:  phase_d = SP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= SP_IDLE;
            sel_q    <= 1'b0;
            word_q   <= '0;
            coeff_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (phase_q == SP_IDLE && start) begin
                word_q <= word;
                sel_q  <= sel_sample;
            end
            // Strobes are decoded from the next phase so they come straight from flops.
            coeff_q  <= (phase_d == SP_PULSE) && !sel_q;
            sample_q <= (phase_d == SP_PULSE) && sel_q;
        end
    end

    assign filt_in       = word_q;
    assign coeff_strobe  = coeff_q;
    assign sample_strobe = sample_q;
    assign busy          = (phase_q != SP_IDLE);
    assign phase         = phase_q;

endmodule

// File: rtl/fir_load_ctrl.sv
// Sequencer for the 64-tap hard FIR.
// Runs the filter reset sequence, then loads TAPS coefficients and one scale word.
// After that it feeds samples, captures each filter result and flags overflow.
// Handshakes: a word moves on a rising clk edge where valid && ready are both high.
// ready never depends on valid, and valid may be held high across stalls.
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   cfg_start               : start reset+load (honoured in IDLE and RUN only)
//   coef_valid/ready/data   : coefficient stream (TAPS words, then the scale word)
//   smp_valid/ready/data    : sample stream (accepted in RUN only)
//   filt_reset/coeff/sample : registered controls to the hard filter
//   filt_in                 : data word to the hard filter
//   filt_out                : hard filter output (signed)
//   result_valid/data/ovf   : captured result pulse, held data, overflow flag
//   loaded                  : coefficients and scale loaded (RUN)
//   busy                    : sequencing or a transfer in flight
//   state                   : current sequencer state (debug visibility)
import fir_ctrl_pkg::*;

module fir_load_ctrl #(
    parameter int TAPS       = 64,
    parameter int DATA_W     = 32,
    parameter int RESULT_LAT = 1,
    parameter int OVF_LIM    = 511
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              smp_valid,
    output logic              smp_ready,
    input  logic [DATA_W-1:0] smp_data,
    output logic              filt_reset,
    output logic              filt_coeff,
    output logic              filt_sample,
    output logic [DATA_W-1:0] filt_in,
    input  logic [DATA_W-1:0] filt_out,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              result_ovf,
    output logic              loaded,
    output logic              busy,
    output ctrl_state_t       state
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic signed [DATA_W-1:0] LIM_POS = DATA_W'(OVF_LIM);
    localparam logic signed [DATA_W-1:0] LIM_NEG = -LIM_POS;

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [1:0]        rst_cnt_q;
    logic [1:0]        rst_cnt_d;

    logic              filt_reset_q;
    logic              rst_strobe_q;

    logic              coef_rdy;
    logic              smp_rdy;
    logic              coef_accept;
    logic              smp_accept;

    logic [DATA_W-1:0] sg_word;
    logic              sg_coeff;
    logic              sg_sample;
    logic              sg_busy;
    strobe_phase_t     sg_phase;

    logic [RESULT_LAT-1:0] lat_sr;
    logic              ovf_c;
    logic              result_valid_q;
    logic              result_ovf_q;
    logic [DATA_W-1:0] result_data_q;

    // ---------------- handshakes ----------------
    assign coef_rdy    = (state_q == LOAD_COEF || state_q == LOAD_SCALE) && !sg_busy;
    // An honoured cfg_start in RUN blocks sample acceptance in the same cycle.
    assign smp_rdy     = (state_q == RUN) && !sg_busy && !cfg_start;
    assign coef_accept = coef_valid && coef_rdy;
    assign smp_accept  = smp_valid && smp_rdy;
    assign sg_word     = smp_accept ? smp_data : coef_data;

    // ---------------- FSM ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            IDLE, RUN: begin
                if (cfg_start) begin
                    state_d   = RST_SEQ;
                    rst_cnt_d = 2'd0;
                    cnt_d     = '0;
                end
            end
            RST_SEQ: begin
                if (rst_cnt_q == 2'(RST_SEQ_LEN - 1)) begin
                    state_d = LOAD_COEF;
                    cnt_d   = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 2'd1;
                end
            end
            LOAD_COEF: begin
                // Count completed pulses; the last one hands over to the scale word.
                if (sg_phase == SP_PULSE) begin
                    if (cnt_q == CNT_W'(TAPS - 1)) begin
                        state_d = LOAD_SCALE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_SCALE: begin
                if (sg_phase == SP_PULSE) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rst_cnt_q    <= 2'd0;
            filt_reset_q <= 1'b0;
            rst_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            // Reset sequence: filt_reset high in the first two cycles.
            // Both strobes pulse in the middle cycle.
            filt_reset_q <= (state_d == RST_SEQ) && (rst_cnt_d != 2'(RST_SEQ_LEN - 1));
            rst_strobe_q <= (state_d == RST_SEQ) && (rst_cnt_d == 2'd1);
        end
    end

    // ---------------- word transfer ----------------
    fir_strobe_gen #(
        .DATA_W (DATA_W)
    ) u_strobe (
        .clk           (clk),
        .reset         (reset),
        .start         (coef_accept || smp_accept),
        .sel_sample    (smp_accept),
        .word          (sg_word),
        .filt_in       (filt_in),
        .coeff_strobe  (sg_coeff),
        .sample_strobe (sg_sample),
        .busy          (sg_busy),
        .phase         (sg_phase)
    );

    // ---------------- result capture ----------------
    // lat_sr[i] is high i+1 cycles after the sample pulse.
    // The capture edge closes cycle P+RESULT_LAT.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_sr <= '0;
        end else begin
            lat_sr[0] <= sg_sample;
            for (int i = 1; i < RESULT_LAT; i++) begin
                lat_sr[i] <= lat_sr[i-1];
            end
        end
    end

    assign ovf_c = ($signed(filt_out) > LIM_POS) || ($signed(filt_out) < LIM_NEG);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid_q <= 1'b0;
            result_ovf_q   <= 1'b0;
            result_data_q  <= '0;
        end else begin
            result_valid_q <= lat_sr[RESULT_LAT-1];
            result_ovf_q   <= lat_sr[RESULT_LAT-1] && ovf_c;
            if (lat_sr[RESULT_LAT-1]) result_data_q <= filt_out;
        end
    end

    // ---------------- outputs ----------------
    assign coef_ready   = coef_rdy;
    assign smp_ready    = smp_rdy;
    assign filt_reset   = filt_reset_q;
    assign filt_coeff   = rst_strobe_q || sg_coeff;
    assign filt_sample  = rst_strobe_q || sg_sample;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign result_ovf   = result_ovf_q;
    assign loaded       = (state_q == RUN);
    assign busy         = (state_q == RST_SEQ) || (state_q == LOAD_COEF) ||
                          (state_q == LOAD_SCALE) || sg_busy;
    assign state        = state_q;

endmodule
